stream_demux_1xn: RTL and testbench
===================================

// Module: stream_demux_1xn
// PURPOSE
//  Parametrised 1-to-NCH packet demultiplexer with valid/ready handshake on every port.
//  It supersedes the fixed 3-bit-select 1x8 gate demux on streaming datapaths.
//  The channel is locked per packet: in_sel is sampled on the first beat and held until in_last.
//  Each output has a one-entry register, so a stalled channel does not corrupt other channels.
// PARAMETERS
//  NCH   8  number of output channels (>=2; need not be a power of 2)
//  DW    8  data width per beat
//  SELW  $clog2(NCH)  localparam, select width
//  CNTW  8  width of drop counter (used only with DEMUX_DROP_CNT_EN)
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        synchronous, active-high reset
//  in_data    in   DW       input beat data
//  in_sel     in   SELW     destination channel, sampled on first beat of packet
//  in_valid   in   1        input beat valid
//  in_last    in   1        final beat of packet
//  in_ready   out  1        input beat accepted when in_valid&&in_ready
//  out_data   out  NCH*DW   channel k data at [k*DW +: DW]
//  out_valid  out  NCH      per-channel valid
//  out_last   out  NCH      per-channel last flag
//  out_ready  in   NCH      per-channel ready
//  busy       out  1        1 while a multi-beat packet is open (state != IDLE)
//  drop_cnt   out  CNTW     dropped-packet count (present only with DEMUX_DROP_CNT_EN)
// BEHAVIOUR
//  - Reset: state=IDLE, cur_sel=0, all out_valid/out_last/out_data=0, drop_cnt=0; in_ready=0 while rst=1.
//  - FSM states:
//    IDLE: target = in_sel.
//    ROUTE: target = cur_sel; in_sel is ignored.
//    DROP: target invalid; all beats are discarded.
//  - IDLE transitions on an accepted beat:
//    in_last=1 -> stay IDLE (single-beat packet).
//    in_sel<NCH and in_last=0 -> capture cur_sel=in_sel, go ROUTE.
//    in_sel>=NCH and in_last=0 -> go DROP.
//  - ROUTE/DROP: an accepted beat with in_last=1 -> IDLE.
//  - in_ready = (target<NCH) ? (!out_valid[target] || out_ready[target]) : 1.
//    Combinational path from out_ready to in_ready is permitted.
//  - Latency: a beat accepted at edge t appears on out_*[target] after edge t (1 cycle).
//    out_valid holds, data stable, until out_ready=1. Load and drain in the same cycle sustains 1 beat/clk.
//  - A channel that is not targeted only drains; out_data of idle channels keeps its last value.
//  - Invalid select (in_sel>=NCH on first beat): the whole packet is accepted and discarded; no output asserts.
//  - Reset mid-packet: buffered beats are lost; FSM returns to IDLE.
//    The next beat after reset is treated as a first beat.
// CONFIGURATION
//  DEMUX_DROP_CNT_EN defined:
//    drop_cnt port exists. It increments by 1 when a packet enters DROP or is a single-beat invalid-sel packet.
//    It saturates at 2**CNTW-1 and is cleared by rst.
//  Not defined: port and counter are absent; drop behaviour is unchanged.
// STRUCTURE
//  Package stream_demux_pkg: typedef enum logic[1:0] {ST_IDLE, ST_ROUTE, ST_DROP} demux_state_t.
//  The package also holds ST_* encodings used by the bench for FSM probing.
//  Sub-module demux_out_reg (DW, one-entry register slice: load/valid/last/ready) is instantiated NCH times via generate.
//  FSM, target decode, in_ready mux and drop counter live in stream_demux_1xn.
// TESTING
//  1. NCH=8, single beats sel=0..7, out_ready all 1
//     -> each beat appears on out_data[k] 1 cycle later; in_ready stays 1; out_last=1.
//  2. 4-beat packet sel=5, in_sel toggled to 2 after beat 1
//     -> all 4 beats appear on ch5 only; busy=1 beats 2-4; IDLE after last.
//  3. ch3 out_ready=0, back-to-back packet to ch3
//     -> first beat held on ch3; in_ready=0; no loss.
//     Release ready -> 1 beat/clk throughput.
//  4. NCH=6, packet sel=7 of 3 beats
//     -> in_ready=1 throughout; no out_valid; drop_cnt 0->1 (with DEMUX_DROP_CNT_EN).
//  5. Assert rst for 1 cycle mid 4-beat packet to ch1
//     -> out_valid=0 next cycle; busy=0; next beat with sel=4 routes to ch4.
//  6. With CNTW=2, send 5 invalid packets -> drop_cnt saturates at 3.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// Shared types for the 1-to-NCH packet demultiplexer: FSM state encoding
// used by the RTL and by benches that probe the FSM.
package stream_demux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUTE = 2'd1,
        ST_DROP  = 2'd2
    } demux_state_t;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_ROUTE_ENC = 2'd1;
    localparam logic [1:0] ST_DROP_ENC  = 2'd2;

endpackage

// File: rtl/stream_demux_1xn_if.sv
// Stream bus for stream_demux_1xn: one input stream, NCH flattened output streams.
interface stream_demux_1xn_if #(
    parameter int NCH  = 8,
    parameter int DW   = 8,
    parameter int SELW = $clog2(NCH)
);
    logic [DW-1:0]     in_data;
    logic [SELW-1:0]   in_sel;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [NCH*DW-1:0] out_data;
    logic [NCH-1:0]    out_valid;
    logic [NCH-1:0]    out_last;
    logic [NCH-1:0]    out_ready;

    // master: upstream producer plus downstream consumers
    modport master (
        output in_data, in_sel, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

    modport slave (
        input  in_data, in_sel, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/demux_out_reg.sv
// One-entry output register slice for a single demux channel.
// Data/last hold their last value after draining; only valid drops.
module demux_out_reg #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] ld_data,
    input  logic          ld_last,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    output logic          out_last,
    input  logic          out_ready,
    output logic          can_load
);
    // Empty, or draining this cycle: a load keeps 1 beat/clk throughput
    assign can_load = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_data  <= ld_data;
            out_last  <= ld_last;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/stream_demux_1xn.sv
// 1-to-NCH packet demultiplexer; channel locked per packet from the first beat.
// Optional DEMUX_DROP_CNT_EN adds a saturating count of invalid-select packets.
module stream_demux_1xn
    import stream_demux_pkg::*;
#(
    parameter int NCH  = 8,
    parameter int DW   = 8,
    parameter int CNTW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    stream_demux_1xn_if.slave    bus,
    output logic                 busy
`ifdef DEMUX_DROP_CNT_EN
    ,
    output logic [CNTW-1:0]      drop_cnt
`endif
);
    localparam int SELW = $clog2(NCH);
    localparam int NPAD = 1 << SELW;
    localparam logic [SELW:0] NCH_W = (SELW+1)'(NCH);

    demux_state_t    state;
    logic [SELW-1:0] cur_sel;
    logic [SELW-1:0] target_sel;
    logic            in_sel_ok;
    logic            target_ok;
    logic            accept;
    logic [NCH-1:0]  can_load;
    logic [NPAD-1:0] can_load_pad;

    assign in_sel_ok  = ({1'b0, bus.in_sel} < NCH_W);
    assign target_sel = (state == ST_IDLE) ? bus.in_sel : cur_sel;
    assign target_ok  = (state == ST_ROUTE) || ((state == ST_IDLE) && in_sel_ok);

    // Unused select codes read as ready so the mux index is always in range
    always_comb begin
        can_load_pad = '1;
        can_load_pad[NCH-1:0] = can_load;
    end

    assign bus.in_ready = !rst && (target_ok ? can_load_pad[target_sel] : 1'b1);
    assign accept       = bus.in_valid && bus.in_ready;
    assign busy         = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cur_sel <= '0;
        end else if (accept) begin
            case (state)
                ST_IDLE: begin
                    if (!bus.in_last) begin
                        if (in_sel_ok) begin
                            cur_sel <= bus.in_sel;
                            state   <= ST_ROUTE;
                        end else begin
                            state   <= ST_DROP;
                        end
                    end
                end
                ST_ROUTE, ST_DROP: begin
                    if (bus.in_last) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic load;
        assign load = accept && target_ok && (target_sel == SELW'(k));

        demux_out_reg #(.DW(DW)) u_reg (
            .clk       (clk),
            .rst       (rst),
            .load      (load),
            .ld_data   (bus.in_data),
            .ld_last   (bus.in_last),
            .out_data  (bus.out_data[k*DW +: DW]),
            .out_valid (bus.out_valid[k]),
            .out_last  (bus.out_last[k]),
            .out_ready (bus.out_ready[k]),
            .can_load  (can_load[k])
        );
    end

`ifdef DEMUX_DROP_CNT_EN
    logic drop_evt;
    // First beat with a bad select: covers both DROP entry and single-beat drops
    assign drop_evt = accept && (state == ST_IDLE) && !in_sel_ok;

    always_ff @(posedge clk) begin
        if (rst)                         drop_cnt <= '0;
        else if (drop_evt && !(&drop_cnt)) drop_cnt <= drop_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_stream_demux_1xn.sv
// Scoreboard bench for stream_demux_1xn (NCH=6, so selects 6/7 are invalid).
module tb_stream_demux_1xn;
    localparam int NCH  = 6;
    localparam int DW   = 8;
    localparam int CNTW = 2;
    localparam int SELW = 3;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    logic busy;
`ifdef DEMUX_DROP_CNT_EN
    logic [CNTW-1:0] drop_cnt;
`endif

    always #5 clk = ~clk;

    stream_demux_1xn_if #(.NCH(NCH), .DW(DW)) bus ();

    stream_demux_1xn #(.NCH(NCH), .DW(DW), .CNTW(CNTW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .busy     (busy)
`ifdef DEMUX_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    beat_t expq[NCH][$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Monitor: pops on each output handshake, flags any unexpected valid
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NCH; k++) begin
                if (bus.out_valid[k]) begin
                    if (expq[k].size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_valid ch%0d actual=%0h required=none", k,
                                 bus.out_data[k*DW +: DW]);
                    end else if (bus.out_ready[k]) begin
                        beat_t b;
                        b = expq[k].pop_front();
                        chk($sformatf("ch%0d_data", k), bus.out_data[k*DW +: DW], b.d);
                        chk($sformatf("ch%0d_last", k), bus.out_last[k], b.l);
                    end
                end
            end
        end
    end

    // Called just after a posedge; returns just after the accepting posedge
    task automatic send_beat(input int sel, input int d, input bit last,
                             input int exp_ch, output int waits);
        bit ok;
        bus.in_sel   = sel[SELW-1:0];
        bus.in_data  = d[DW-1:0];
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        waits = 0;
        ok = 1'b0;
        while (!ok) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
            end else begin
                waits++;
                if (waits > 200) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL accept_timeout sel=%0d actual=stalled required=accepted", sel);
                    break;
                end
                @(posedge clk);
                #1;
            end
        end
        if (ok && exp_ch >= 0) expq[exp_ch].push_back('{d: d[DW-1:0], l: last});
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic chk_drop(input int exp);
`ifdef DEMUX_DROP_CNT_EN
        chk("drop_cnt", drop_cnt, exp);
`else
        if (exp < 0) $display("drop count unused");
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_sel    = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = '1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_busy", busy, 0);
        chk_drop(0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // T1: single beats on every select; 6 and 7 are dropped
        for (int s = 0; s < 8; s++) begin
            send_beat(s, 8'h10 + s, 1'b1, (s < NCH) ? s : -1, w);
            chk($sformatf("t1_wait%0d", s), w, 0);
            if (s < NCH) chk($sformatf("t1_lat%0d", s), bus.out_valid[s], 1);
            else         chk($sformatf("t1_nov%0d", s), bus.out_valid, 0);
        end
        repeat (2) @(posedge clk);
        #1;
        chk_drop(2);

        // T2: 4-beat packet locked to ch5 while in_sel moves to 2
        send_beat(5, 8'hA0, 1'b0, 5, w);
        chk("t2_busy1", busy, 1);
        send_beat(2, 8'hA1, 1'b0, 5, w);
        chk("t2_busy2", busy, 1);
        send_beat(2, 8'hA2, 1'b0, 5, w);
        chk("t2_busy3", busy, 1);
        send_beat(2, 8'hA3, 1'b1, 5, w);
        chk("t2_idle", busy, 0);

        // T3: stalled ch3 back-pressures the input, then 1 beat/clk after release
        bus.out_ready[3] = 1'b0;
        send_beat(3, 8'hB0, 1'b1, 3, w);
        bus.in_sel   = 3'd3;
        bus.in_data  = 8'hB1;
        bus.in_last  = 1'b0;
        bus.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t3_stall_ready", bus.in_ready, 0);
            chk("t3_hold_data", bus.out_data[3*DW +: DW], 8'hB0);
            chk("t3_hold_valid", bus.out_valid[3], 1);
        end
        @(posedge clk);
        #1;
        bus.out_ready[3] = 1'b1;
        send_beat(3, 8'hB1, 1'b0, 3, w);
        chk("t3_wait1", w, 0);
        send_beat(3, 8'hB2, 1'b0, 3, w);
        chk("t3_wait2", w, 0);
        send_beat(3, 8'hB3, 1'b1, 3, w);
        chk("t3_wait3", w, 0);

        // T4: 3-beat packet to invalid select 7 is swallowed
        send_beat(7, 8'hC0, 1'b0, -1, w);
        chk("t4_wait1", w, 0);
        chk("t4_busy", busy, 1);
        send_beat(7, 8'hC1, 1'b0, -1, w);
        chk("t4_wait2", w, 0);
        send_beat(7, 8'hC2, 1'b1, -1, w);
        chk("t4_wait3", w, 0);
        chk("t4_idle", busy, 0);
        chk_drop(3);

        // T5: reset mid-packet to ch1 loses the buffered beat
        bus.out_ready[1] = 1'b0;
        send_beat(1, 8'hD0, 1'b0, 1, w);
        chk("t5_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < NCH; k++) expq[k].delete();
        chk("t5_out_valid", bus.out_valid, 0);
        chk("t5_busy_rst", busy, 0);
        chk_drop(0);
        bus.out_ready[1] = 1'b1;
        send_beat(4, 8'hE0, 1'b0, 4, w);
        chk("t5_ch4_valid", bus.out_valid[4], 1);
        send_beat(1, 8'hE1, 1'b1, 4, w);

        // T6: five invalid single-beat packets saturate the 2-bit counter
        for (int i = 0; i < 5; i++) begin
            send_beat(6, 8'hF0 + i, 1'b1, -1, w);
            if (i == 2) chk_drop(3);
        end
        chk_drop(3);

        repeat (4) @(posedge clk);
        #1;
        for (int k = 0; k < NCH; k++) chk($sformatf("drain_ch%0d", k), expq[k].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
